// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
// The bit-time helper turns a prescale value into a down-counter reload.
package uart_pkg;

    localparam int DATA_BITS_DEFAULT = 8;
    localparam int OVERSAMPLE_SHIFT  = 3;
    localparam int BIT_CNT_W         = 16 + OVERSAMPLE_SHIFT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Reload value for a down-counter that expires (p << shift) cycles later.
    function automatic logic [BIT_CNT_W-1:0] bit_ticks(input logic [15:0] p, input int shift);
        logic [BIT_CNT_W-1:0] w_ext;
        w_ext = {{(BIT_CNT_W-16){1'b0}}, p};
        return (w_ext << shift) - {{(BIT_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/uart_rx_axis_if.sv
// AXI-Stream style byte channel carried out of the UART receiver.
interface uart_rx_axis_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT
) ();

    logic [DATA_BITS-1:0] m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;

    modport master (
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready
    );

    modport slave (
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high serial line.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Resets to the idle-high level so no false start follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver with 8x-prescaled bit timing and an AXI-Stream output.
// Frame results are issued one cycle after the stop-bit sample.
module uart_rx_axis
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rxd,
    input  logic [15:0]    prescale,
    uart_rx_axis_if.master m_axis,
    output logic           busy,
    output logic           overrun_error,
    output logic           frame_error
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);

    logic                 w_rxs;
    logic                 w_cnt_zero;
    uart_state_e          r_state;
    logic [BIT_CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [15:0]          r_p;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_tdata;
    logic                 r_rxs_prev;
    logic                 r_pend;
    logic                 r_stop_ok;
    logic                 r_tvalid;
    logic                 r_busy;
    logic                 r_ovr;
    logic                 r_ferr;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rxd),
        .o_q (w_rxs)
    );

    assign w_cnt_zero = (r_cnt == {BIT_CNT_W{1'b0}});

    // Frame FSM plus the output stage that retires a sampled frame one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= {BIT_CNT_W{1'b0}};
            r_bit_idx  <= {IDX_W{1'b0}};
            r_p        <= 16'd0;
            r_shift    <= {DATA_BITS{1'b0}};
            r_tdata    <= {DATA_BITS{1'b0}};
            r_rxs_prev <= 1'b1;
            r_pend     <= 1'b0;
            r_stop_ok  <= 1'b0;
            r_tvalid   <= 1'b0;
            r_busy     <= 1'b0;
            r_ovr      <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_rxs_prev <= w_rxs;
            r_ovr      <= 1'b0;
            r_ferr     <= 1'b0;

            if (r_tvalid && m_axis.m_axis_tready) begin
                r_tvalid <= 1'b0;
            end

            // A concurrent accept frees the slot, so a new byte then is not an overrun.
            if (r_pend) begin
                r_pend <= 1'b0;
                r_busy <= 1'b0;
                if (r_stop_ok) begin
                    r_tdata  <= r_shift;
                    r_tvalid <= 1'b1;
                    r_ovr    <= r_tvalid && !m_axis.m_axis_tready;
                end else begin
                    r_ferr <= 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    if ((prescale != 16'd0) && !w_rxs && r_rxs_prev) begin
                        r_p     <= prescale;
                        r_cnt   <= bit_ticks(prescale, OVERSAMPLE_SHIFT - 1);
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_cnt_zero) begin
                        if (w_rxs) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt     <= bit_ticks(r_p, OVERSAMPLE_SHIFT);
                            r_bit_idx <= {IDX_W{1'b0}};
                            r_state   <= DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt - {{(BIT_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                DATA: begin
                    if (w_cnt_zero) begin
                        r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                        r_cnt   <= bit_ticks(r_p, OVERSAMPLE_SHIFT);
                        if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + {{(IDX_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        r_cnt <= r_cnt - {{(BIT_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                STOP: begin
                    if (w_cnt_zero) begin
                        r_stop_ok <= w_rxs;
                        r_pend    <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - {{(BIT_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m_axis.m_axis_tdata  = r_tdata;
    assign m_axis.m_axis_tvalid = r_tvalid;
    assign busy                 = r_busy;
    assign overrun_error        = r_ovr;
    assign frame_error          = r_ferr;

endmodule
